// File: rtl/ipm_mult_seq.sv
// rtl/ipm_mult_seq.sv - row-serial handshake IPM multiplier over GF(2^8), poly 0x11B
//
// Computes T = R * Q in the inner-product-masking domain for LANES independent
// channels of N shares each, one share row of R per clock.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid       / in_ready  bundle accepted (IDLE only)
//   r_in,q_in  operand shares, lane l share i at [(l*N+i)*8 +: 8]
//   lhat_in    Lhat[i][j] = L_i*L_j at [(l*N*N+i*N+j)*8 +: 8]
//   rand_in    fresh masks r_j (j=1..N-1) at [(l*(N-1)+j-1)*8 +: 8]
//   out_valid  product bundle valid       / out_ready downstream accepts
//   t_out      product shares, same packing as r_in
//   busy       high outside IDLE
// Optional feature macro: IPM_SEQ_CLEAR_EN (zero operand/acc/T registers on the
// output handshake edge so no share remnants stay in flops).
module ipm_mult_seq #(
  parameter int N     = 8,
  parameter int LANES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*N*8-1:0]       r_in,
  input  logic [LANES*N*8-1:0]       q_in,
  input  logic [LANES*N*N*8-1:0]     lhat_in,
  input  logic [LANES*(N-1)*8-1:0]   rand_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*N*8-1:0]       t_out,
  output logic                       busy
);

`ifdef IPM_SEQ_CLEAR_EN
  localparam bit CLEAR_ON_HS = 1'b1;
`else
  localparam bit CLEAR_ON_HS = 1'b0;
`endif

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_ROW, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              row_q, row_d;
  logic [LANES*N*8-1:0]       r_q, q_q;
  logic [LANES*N*N*8-1:0]     lhat_q;
  logic [LANES*(N-1)*8-1:0]   rand_q;
  // Shares 1..N-1 of T; share 0 is the accumulator itself.
  logic [LANES*(N-1)*8-1:0]   t_q;
  logic [LANES*8-1:0]         acc_q;
  logic [LANES*8-1:0]         seed_acc, row_acc;
  int                         row_idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_SEED;
        row_d   = '0;
      end
      S_SEED: state_d = S_ROW;
      S_ROW: begin
        if (row_q == CW'(N - 1)) begin
          state_d = S_DONE;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign row_idx = int'(row_q);

  // Per-lane seed mask term and the current row's partial products.
  always_comb begin
    seed_acc = '0;
    row_acc  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 1; j < N; j++) begin
        seed_acc[l*8 +: 8] ^= gf_mul(lhat_q[(l*N*N + j)*8 +: 8],
                                     rand_q[(l*(N-1) + j - 1)*8 +: 8]);
      end
      for (int j = 0; j < N; j++) begin
        row_acc[l*8 +: 8] ^= gf_mul(lhat_q[(l*N*N + row_idx*N + j)*8 +: 8],
                                    gf_mul(r_q[(l*N + row_idx)*8 +: 8],
                                           q_q[(l*N + j)*8 +: 8]));
      end
    end
  end

  // Operand capture and accumulation datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      lhat_q <= '0;
      rand_q <= '0;
      t_q    <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          r_q    <= r_in;
          q_q    <= q_in;
          lhat_q <= lhat_in;
          rand_q <= rand_in;
        end
        S_SEED: begin
          t_q   <= rand_q;
          acc_q <= seed_acc;
        end
        S_ROW: acc_q <= acc_q ^ row_acc;
        S_DONE: if (CLEAR_ON_HS && out_ready) begin
          r_q    <= '0;
          q_q    <= '0;
          lhat_q <= '0;
          rand_q <= '0;
          t_q    <= '0;
          acc_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    t_out = '0;
    for (int l = 0; l < LANES; l++) begin
      t_out[(l*N)*8 +: 8] = acc_q[l*8 +: 8];
      for (int j = 1; j < N; j++) begin
        t_out[(l*N + j)*8 +: 8] = t_q[(l*(N-1) + j - 1)*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ipm_mult_seq.sv
// tb/tb_ipm_mult_seq.sv - self-checking bench for ipm_mult_seq
module tb_ipm_mult_seq;
  localparam int NS = 2, LS = 1, NB = 8, LB = 2;

`ifdef IPM_SEQ_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk;
  logic rst_n_s, rst_n_b;

  logic                     s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [LS*NS*8-1:0]       s_r, s_q, s_t;
  logic [LS*NS*NS*8-1:0]    s_lhat;
  logic [LS*(NS-1)*8-1:0]   s_rand;

  logic                     b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [LB*NB*8-1:0]       b_r, b_q, b_t_out;
  logic [LB*NB*NB*8-1:0]    b_lhat;
  logic [LB*(NB-1)*8-1:0]   b_rand;

  int n_checks = 0;
  int n_fail   = 0;

  ipm_mult_seq #(.N(NS), .LANES(LS)) u_small (
    .clk(clk), .rst_n(rst_n_s), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .r_in(s_r), .q_in(s_q), .lhat_in(s_lhat), .rand_in(s_rand),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .t_out(s_t), .busy(s_busy));

  ipm_mult_seq #(.N(NB), .LANES(LB)) u_big (
    .clk(clk), .rst_n(rst_n_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .r_in(b_r), .q_in(b_q), .lhat_in(b_lhat), .rand_in(b_rand),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .t_out(b_t_out), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkv(name, 128'(act), 128'(exp));
  endtask

  // Reference GF(2^8) multiply: full carry-less product, then polynomial division by 0x11B.
  function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p ^= 16'(a) << k;
    for (int k = 15; k >= 8; k--) if (p[k]) p ^= 16'h011B << (k - 8);
    return p[7:0];
  endfunction

  // ---------------- big-instance stimulus state and model ----------------
  logic [7:0] cL [LB][NB];
  logic [7:0] cR [LB][NB];
  logic [7:0] cQ [LB][NB];
  logic [7:0] cRnd [LB][NB];
  logic [7:0] mL [LB][NB];
  logic [7:0] mR [LB][NB];
  logic [7:0] mQ [LB][NB];

  bit           pend = 1'b0;
  int           age = 0;
  int           accepted = 0;
  int           n_hs = 0;
  logic [127:0] exp_t = '0;
  logic [127:0] idle_t = '0;
  logic [7:0]   inv_lhs, inv_a, inv_b;

  task automatic drive_big(input bit v);
    for (int l = 0; l < LB; l++) begin
      for (int i = 0; i < NB; i++) begin
        cL[l][i]   = (i == 0) ? 8'h01 : 8'($urandom_range(1, 255));
        cR[l][i]   = 8'($urandom);
        cQ[l][i]   = 8'($urandom);
        cRnd[l][i] = 8'($urandom);
        b_r[(l*NB + i)*8 +: 8] = cR[l][i];
        b_q[(l*NB + i)*8 +: 8] = cQ[l][i];
        if (i > 0) b_rand[(l*(NB-1) + i - 1)*8 +: 8] = cRnd[l][i];
      end
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < NB; j++)
          b_lhat[(l*NB*NB + i*NB + j)*8 +: 8] = gf(cL[l][i], cL[l][j]);
    end
    b_in_valid = v;
  endtask

  // Product shares from the algebra: T_j = r_j (j>=1), T_0 = R*Q ^ sum_j L_j*r_j.
  function automatic logic [127:0] model_t();
    logic [127:0] t;
    logic [7:0] sr, sq, mk;
    t = '0;
    for (int l = 0; l < LB; l++) begin
      sr = '0; sq = '0; mk = '0;
      for (int i = 0; i < NB; i++) begin
        sr ^= gf(cL[l][i], cR[l][i]);
        sq ^= gf(cL[l][i], cQ[l][i]);
      end
      for (int j = 1; j < NB; j++) begin
        mk ^= gf(cL[l][j], cRnd[l][j]);
        t[(l*NB + j)*8 +: 8] = cRnd[l][j];
      end
      t[(l*NB)*8 +: 8] = gf(sr, sq) ^ mk;
    end
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst_n_b) begin
      pend   = 1'b0;
      idle_t = '0;
      chk1("b_rst_in_ready", b_in_ready, 1'b1);
      chk1("b_rst_out_valid", b_out_valid, 1'b0);
      chk1("b_rst_busy", b_busy, 1'b0);
      chkv("b_rst_t_out", b_t_out, 128'd0);
    end else begin
      chk1("b_in_ready", b_in_ready, !pend);
      chk1("b_busy", b_busy, pend);
      chk1("b_out_valid", b_out_valid, pend && age == NB + 1);
      chk1("b_no_overlap", b_out_valid & b_in_ready, 1'b0);
      if (pend && age == NB + 1) begin
        chkv("b_t_out", b_t_out, exp_t);
        for (int l = 0; l < LB; l++) begin
          inv_lhs = '0; inv_a = '0; inv_b = '0;
          for (int i = 0; i < NB; i++) begin
            inv_lhs ^= gf(mL[l][i], b_t_out[(l*NB + i)*8 +: 8]);
            inv_a   ^= gf(mL[l][i], mR[l][i]);
            inv_b   ^= gf(mL[l][i], mQ[l][i]);
          end
          chkv("b_invariant", 128'(inv_lhs), 128'(gf(inv_a, inv_b)));
        end
      end else if (!pend) begin
        chkv("b_t_idle", b_t_out, idle_t);
      end
      // Advance the model across the coming rising edge.
      if (pend) begin
        if (age == NB + 1) begin
          if (b_out_ready) begin
            pend   = 1'b0;
            n_hs++;
            idle_t = CLR ? 128'd0 : exp_t;
          end
        end else begin
          age++;
        end
      end else if (b_in_valid) begin
        pend  = 1'b1;
        age   = 0;
        accepted++;
        exp_t = model_t();
        mL = cL; mR = cR; mQ = cQ;
      end
    end
  end

  // ---------------- small-instance directed vectors ----------------
  task automatic small_op(input logic [15:0] r, input logic [15:0] q, input logic [7:0] rnd,
                          input logic [15:0] exp, input int stall);
    @(posedge clk); #1;
    s_r = r; s_q = q; s_lhat = 32'h04020201; s_rand = rnd;
    s_in_valid = 1'b1;
    s_out_ready = (stall == 0);
    @(posedge clk);  // accepting edge
    for (int k = 0; k < NS + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_in_valid = 1'b0;
        s_lhat = 32'hDEADBEEF; s_r = 16'hFFFF; s_q = 16'h1234; s_rand = 8'h77;
      end
      chk1("s_valid_early", s_out_valid, 1'b0);
      chk1("s_ready_busy", s_in_ready, 1'b0);
      chk1("s_busy", s_busy, 1'b1);
    end
    @(negedge clk);
    chk1("s_valid_rise", s_out_valid, 1'b1);
    chkv("s_t_out", 128'(s_t), 128'(exp));
    chkv("s_invariant", 128'(s_t[7:0] ^ gf(8'h02, s_t[15:8])), 128'(8'h01));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk1("s_stall_valid", s_out_valid, 1'b1);
      chk1("s_stall_ready", s_in_ready, 1'b0);
      chkv("s_stall_t", 128'(s_t), 128'(exp));
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    chk1("s_hs_valid", s_out_valid, 1'b0);
    chk1("s_hs_ready", s_in_ready, 1'b1);
    chkv("s_idle_t", 128'(s_t), CLR ? 128'd0 : 128'(exp));
    @(negedge clk);
    chk1("s_single_hs", s_out_valid, 1'b0);
  endtask

  initial begin
    int hs0;
    int cyc;
    rst_n_s = 1'b1; rst_n_b = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_r = '0; s_q = '0; s_lhat = '0; s_rand = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_r = '0; b_q = '0; b_lhat = '0; b_rand = '0;
    #1;
    rst_n_s = 1'b0; rst_n_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("s_rst_in_ready", s_in_ready, 1'b1);
    chk1("s_rst_out_valid", s_out_valid, 1'b0);
    chk1("s_rst_busy", s_busy, 1'b0);
    chkv("s_rst_t", 128'(s_t), 128'd0);
    chkv("gf_pin_57_83", 128'(gf(8'h57, 8'h83)), 128'(8'hC1));
    chkv("gf_pin_53_ca", 128'(gf(8'h53, 8'hCA)), 128'(8'h01));
    chkv("gf_pin_02_5a", 128'(gf(8'h02, 8'h5A)), 128'(8'hB4));
    @(posedge clk); #1;
    rst_n_s = 1'b1; rst_n_b = 1'b1;

    small_op(16'h0053, 16'h00CA, 8'h00, 16'h0001, 0);
    small_op(16'h0053, 16'h00CA, 8'h5A, 16'h5AB5, 10);

    // Random bundles with random valid/ready pressure on the big instance.
    cyc = 0;
    while (accepted < 1000 && cyc < 40000) begin
      @(posedge clk); #1;
      drive_big($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    chk1("b_bundles_done", accepted >= 1000, 1'b1);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 50 && pend; k++) @(posedge clk);
    @(negedge clk);
    chk1("b_drained", b_busy, 1'b0);

    // Abort in ROW row 3, then a fresh bundle must come out right.
    @(posedge clk); #1;
    drive_big(1'b1);
    @(posedge clk); #1;   // accepting edge
    b_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n_b = 1'b0;
    @(negedge clk);
    chk1("b_abort_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    @(negedge clk);
    chk1("b_abort_ready", b_in_ready, 1'b1);
    hs0 = n_hs;
    @(posedge clk); #1;
    drive_big(1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int k = 0; k < 40 && n_hs == hs0; k++) @(posedge clk);
    chk1("b_post_abort_hs", n_hs == hs0 + 1, 1'b1);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
